// File: rtl/cphase_rotation_gate_pkg.sv
// Shared fixed-point and phase-constant definitions for the QFT rotation stages.
// Amplitudes are signed S3.4; phase coefficients (c, s) approximate
// cos/sin(2*pi/2^k) in the same format.
package cphase_rotation_gate_pkg;

  localparam int QFT_TOTAL_WIDTH = 8;
  localparam int QFT_FRAC_WIDTH  = 4;
  localparam int QFT_LATENCY     = 4;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef logic signed [QFT_TOTAL_WIDTH-1:0] amp_t;

  typedef struct packed {
    amp_t c;
    amp_t s;
  } coef_t;

  // Rotation index; the name records the angle 2*pi/2^k it selects.
  typedef enum logic [2:0] {
    K_IDENT   = 3'd0,
    K_PI      = 3'd1,
    K_HALF_PI = 3'd2,
    K_PI_4    = 3'd3,
    K_PI_8    = 3'd4,
    K_PI_16   = 3'd5,
    K_PI_32   = 3'd6,
    K_PI_64   = 3'd7
  } k_idx_e;

  // k = 0 is the full-turn rotation, i.e. identity.
  localparam coef_t COEF_K0 = '{c:  8'sd16, s: 8'sd0};
  localparam coef_t COEF_K1 = '{c: -8'sd16, s: 8'sd0};
  localparam coef_t COEF_K2 = '{c:  8'sd0,  s: 8'sd16};
  localparam coef_t COEF_K3 = '{c:  8'sd11, s: 8'sd11};
  localparam coef_t COEF_K4 = '{c:  8'sd15, s: 8'sd6};
  localparam coef_t COEF_K5 = '{c:  8'sd16, s: 8'sd3};
  localparam coef_t COEF_K6 = '{c:  8'sd16, s: 8'sd2};
  localparam coef_t COEF_K7 = '{c:  8'sd16, s: 8'sd1};

endpackage

// File: rtl/cphase_rotation_gate_phase_coef_rom.sv
// Combinational k -> (c, s) phase coefficient lookup.
// Kept as its own module so later multi-qubit rotation stages can reuse it.
module phase_coef_rom
  import cphase_rotation_gate_pkg::*;
(
  input  logic [2:0] k,
  output coef_t      coef
);

  // Pure lookup; every index is defined so no default fallback is reachable.
  always_comb begin
    coef = COEF_K0;
    case (k_idx_e'(k))
      K_IDENT:   coef = COEF_K0;
      K_PI:      coef = COEF_K1;
      K_HALF_PI: coef = COEF_K2;
      K_PI_4:    coef = COEF_K3;
      K_PI_8:    coef = COEF_K4;
      K_PI_16:   coef = COEF_K5;
      K_PI_32:   coef = COEF_K6;
      K_PI_64:   coef = COEF_K7;
      default:   coef = COEF_K0;
    endcase
  end

endmodule

// File: rtl/cphase_rotation_gate.sv
// Controlled phase rotation R_k for a two-qubit amplitude vector.
// Only |11> is rotated by e^{i*2*pi/2^k}; |00>, |01>, |10> ride along through
// matching registers so the whole vector leaves together four cycles later.
//
// Pipeline:
//   S1  capture inputs, k and valid; (c, s) looked up from the captured k
//   S2  the four partial products
//   S3  re = ar*c - ai*s, im = ar*s + ai*c
//   S4  >>> FRAC_WIDTH (floor), saturate, drive outputs
// Each stage loads only when its valid bit is set, so outputs hold the last
// valid vector while out_valid is low.
module cphase_rotation_gate
  import cphase_rotation_gate_pkg::*;
#(
  parameter int TOTAL_WIDTH = QFT_TOTAL_WIDTH,
  parameter int FRAC_WIDTH  = QFT_FRAC_WIDTH,
  parameter int LATENCY     = QFT_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst_s_n,
  input  logic                          in_valid,
  input  logic [2:0]                    k,
  input  logic signed [TOTAL_WIDTH-1:0] a00_r,
  input  logic signed [TOTAL_WIDTH-1:0] a00_i,
  input  logic signed [TOTAL_WIDTH-1:0] a01_r,
  input  logic signed [TOTAL_WIDTH-1:0] a01_i,
  input  logic signed [TOTAL_WIDTH-1:0] a10_r,
  input  logic signed [TOTAL_WIDTH-1:0] a10_i,
  input  logic signed [TOTAL_WIDTH-1:0] a11_r,
  input  logic signed [TOTAL_WIDTH-1:0] a11_i,
  output logic                          out_valid,
  output logic signed [TOTAL_WIDTH-1:0] n00_r,
  output logic signed [TOTAL_WIDTH-1:0] n00_i,
  output logic signed [TOTAL_WIDTH-1:0] n01_r,
  output logic signed [TOTAL_WIDTH-1:0] n01_i,
  output logic signed [TOTAL_WIDTH-1:0] n10_r,
  output logic signed [TOTAL_WIDTH-1:0] n10_i,
  output logic signed [TOTAL_WIDTH-1:0] n11_r,
  output logic signed [TOTAL_WIDTH-1:0] n11_i
);

  localparam int PROD_W = 2 * TOTAL_WIDTH;
  localparam int SUM_W  = 2 * TOTAL_WIDTH + 1;
  localparam int NPASS  = 6;

  typedef logic signed [TOTAL_WIDTH-1:0] sig_t;
  typedef logic signed [PROD_W-1:0]      prod_t;
  typedef logic signed [SUM_W-1:0]       sum_t;

  localparam sum_t SAT_HI = SUM_W'(SAT_MAX);
  localparam sum_t SAT_LO = SUM_W'(SAT_MIN);

  // Clamp a scaled sum into the amplitude range.
  function automatic sig_t sat(input sum_t v);
    if (v > SAT_HI) begin
      return sig_t'(SAT_MAX);
    end else if (v < SAT_LO) begin
      return sig_t'(SAT_MIN);
    end else begin
      return v[TOTAL_WIDTH-1:0];
    end
  endfunction

  // Valid shift chain; bit i is the valid flag of stage i+1.
  logic [LATENCY-1:0] vld_q, vld_d;

  // Pass-through amplitudes, order: a00_r, a00_i, a01_r, a01_i, a10_r, a10_i.
  sig_t pass_in [NPASS];
  sig_t pass_s1_q [NPASS], pass_s1_d [NPASS];
  sig_t pass_s2_q [NPASS], pass_s2_d [NPASS];
  sig_t pass_s3_q [NPASS], pass_s3_d [NPASS];
  sig_t pass_s4_q [NPASS], pass_s4_d [NPASS];

  // Rotated-path registers.
  sig_t        a11r_s1_q, a11r_s1_d;
  sig_t        a11i_s1_q, a11i_s1_d;
  logic [2:0]  k_s1_q, k_s1_d;
  coef_t       coef_s1;
  prod_t       p_rc_q, p_rc_d;
  prod_t       p_is_q, p_is_d;
  prod_t       p_rs_q, p_rs_d;
  prod_t       p_ic_q, p_ic_d;
  sum_t        re_q, re_d;
  sum_t        im_q, im_d;
  sum_t        re_sh, im_sh;
  sig_t        n11r_q, n11r_d;
  sig_t        n11i_q, n11i_d;

  phase_coef_rom u_coef_rom (
    .k    (k_s1_q),
    .coef (coef_s1)
  );

  // Valid chain always shifts; a vector is accepted whenever in_valid is high.
  always_comb begin
    vld_d = {vld_q[LATENCY-2:0], in_valid};
  end

  // S1: capture the incoming vector and its k.
  always_comb begin
    pass_in   = '{a00_r, a00_i, a01_r, a01_i, a10_r, a10_i};
    pass_s1_d = pass_s1_q;
    a11r_s1_d = a11r_s1_q;
    a11i_s1_d = a11i_s1_q;
    k_s1_d    = k_s1_q;
    if (in_valid) begin
      pass_s1_d = pass_in;
      a11r_s1_d = a11_r;
      a11i_s1_d = a11_i;
      k_s1_d    = k;
    end
  end

  // S2: partial products of |11> with the looked-up coefficients.
  always_comb begin
    pass_s2_d = pass_s2_q;
    p_rc_d    = p_rc_q;
    p_is_d    = p_is_q;
    p_rs_d    = p_rs_q;
    p_ic_d    = p_ic_q;
    if (vld_q[0]) begin
      pass_s2_d = pass_s1_q;
      p_rc_d    = PROD_W'(a11r_s1_q) * PROD_W'(coef_s1.c);
      p_is_d    = PROD_W'(a11i_s1_q) * PROD_W'(coef_s1.s);
      p_rs_d    = PROD_W'(a11r_s1_q) * PROD_W'(coef_s1.s);
      p_ic_d    = PROD_W'(a11i_s1_q) * PROD_W'(coef_s1.c);
    end
  end

  // S3: complex multiply combine, one guard bit so the sum cannot wrap.
  always_comb begin
    pass_s3_d = pass_s3_q;
    re_d      = re_q;
    im_d      = im_q;
    if (vld_q[1]) begin
      pass_s3_d = pass_s2_q;
      re_d      = SUM_W'(p_rc_q) - SUM_W'(p_is_q);
      im_d      = SUM_W'(p_rs_q) + SUM_W'(p_ic_q);
    end
  end

  // S4: arithmetic shift floors toward -inf, then clamp to the word range.
  always_comb begin
    re_sh     = re_q >>> FRAC_WIDTH;
    im_sh     = im_q >>> FRAC_WIDTH;
    pass_s4_d = pass_s4_q;
    n11r_d    = n11r_q;
    n11i_d    = n11i_q;
    if (vld_q[2]) begin
      pass_s4_d = pass_s3_q;
      n11r_d    = sat(re_sh);
      n11i_d    = sat(im_sh);
    end
  end

  // All state clears on reset, so in-flight vectors are discarded.
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      vld_q     <= '0;
      a11r_s1_q <= '0;
      a11i_s1_q <= '0;
      k_s1_q    <= '0;
      p_rc_q    <= '0;
      p_is_q    <= '0;
      p_rs_q    <= '0;
      p_ic_q    <= '0;
      re_q      <= '0;
      im_q      <= '0;
      n11r_q    <= '0;
      n11i_q    <= '0;
      for (int i = 0; i < NPASS; i++) begin
        pass_s1_q[i] <= '0;
        pass_s2_q[i] <= '0;
        pass_s3_q[i] <= '0;
        pass_s4_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      a11r_s1_q <= a11r_s1_d;
      a11i_s1_q <= a11i_s1_d;
      k_s1_q    <= k_s1_d;
      p_rc_q    <= p_rc_d;
      p_is_q    <= p_is_d;
      p_rs_q    <= p_rs_d;
      p_ic_q    <= p_ic_d;
      re_q      <= re_d;
      im_q      <= im_d;
      n11r_q    <= n11r_d;
      n11i_q    <= n11i_d;
      for (int i = 0; i < NPASS; i++) begin
        pass_s1_q[i] <= pass_s1_d[i];
        pass_s2_q[i] <= pass_s2_d[i];
        pass_s3_q[i] <= pass_s3_d[i];
        pass_s4_q[i] <= pass_s4_d[i];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign n00_r     = pass_s4_q[0];
  assign n00_i     = pass_s4_q[1];
  assign n01_r     = pass_s4_q[2];
  assign n01_i     = pass_s4_q[3];
  assign n10_r     = pass_s4_q[4];
  assign n10_i     = pass_s4_q[5];
  assign n11_r     = n11r_q;
  assign n11_i     = n11i_q;

endmodule

// File: tb/tb_cphase_rotation_gate.sv
// Directed testbench for cphase_rotation_gate. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_cphase_rotation_gate;

  logic clk;
  logic rst_s_n;
  logic in_valid;
  logic [2:0] k;
  logic signed [7:0] a00_r, a00_i, a01_r, a01_i, a10_r, a10_i, a11_r, a11_i;
  logic out_valid;
  logic signed [7:0] n00_r, n00_i, n01_r, n01_i, n10_r, n10_i, n11_r, n11_i;

  int n_cmp;
  int n_err;

  cphase_rotation_gate dut (
    .clk       (clk),
    .rst_s_n   (rst_s_n),
    .in_valid  (in_valid),
    .k         (k),
    .a00_r     (a00_r),
    .a00_i     (a00_i),
    .a01_r     (a01_r),
    .a01_i     (a01_i),
    .a10_r     (a10_r),
    .a10_i     (a10_i),
    .a11_r     (a11_r),
    .a11_i     (a11_i),
    .out_valid (out_valid),
    .n00_r     (n00_r),
    .n00_i     (n00_i),
    .n01_r     (n01_r),
    .n01_i     (n01_i),
    .n10_r     (n10_r),
    .n10_i     (n10_i),
    .n11_r     (n11_r),
    .n11_i     (n11_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector with a00=(pr,pi), a01=(pi,pr), a10=(pr,~pi) so routing errors show.
  task automatic drive_vec(input int kk, input int ar, input int ai, input int pr, input int pi);
    in_valid = 1'b1;
    k        = 3'(kk);
    a11_r    = 8'(ar);
    a11_i    = 8'(ai);
    a00_r    = 8'(pr);
    a00_i    = 8'(pi);
    a01_r    = 8'(pi);
    a01_i    = 8'(pr);
    a10_r    = 8'(pr);
    a10_i    = ~8'(pi);
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    k        = 3'($urandom);
    a00_r    = 8'($urandom);
    a00_i    = 8'($urandom);
    a01_r    = 8'($urandom);
    a01_i    = 8'($urandom);
    a10_r    = 8'($urandom);
    a10_i    = 8'($urandom);
    a11_r    = 8'($urandom);
    a11_i    = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_s_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      in_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, n00_r, n00_i, n01_r, n01_i, n10_r, n10_i, n11_r, n11_i} !== 65'd0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got valid=%0b n11=(%0d,%0d) n00=(%0d,%0d) want all 0",
                 i, out_valid, n11_r, n11_i, n00_r, n00_i);
      end
    end
    rst_s_n = 1'b1;
    drive_vec(0, 20, -12, 1, -1);
    @(negedge clk);
    drive_idle();
    for (int j = 1; j < 4; j++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_early_valid[%0d]: got %0b want 0", j, out_valid);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_valid: got %0b want 1", out_valid);
    end
    n_cmp++;
    if ({n11_r, n11_i, n00_r, n00_i} !== {8'sd20, -8'sd12, 8'sd1, -8'sd1}) begin
      n_err++;
      $display("FAIL reset_first_data: got n11=(%0d,%0d) n00=(%0d,%0d) want n11=(20,-12) n00=(1,-1)",
               n11_r, n11_i, n00_r, n00_i);
    end
    @(negedge clk);
  endtask

  // Columns: k, a11_r, a11_i, pass_r, pass_i, exp n11_r, exp n11_i.
  task automatic test_rotation();
    int tab [3][7] = '{'{3, 16, 0, 5, -3, 11, 11},
                       '{1, 16, 0, 5, -3, -16, 0},
                       '{2, 8, 4, -7, 9, -4, 8}};
    logic signed [7:0] er, ei, pr, pi;
    for (int i = 0; i < 3; i++) begin
      er = 8'(tab[i][5]);
      ei = 8'(tab[i][6]);
      pr = 8'(tab[i][3]);
      pi = 8'(tab[i][4]);
      drive_vec(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rot_early_valid[%0d]: got %0b want 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rot_valid[%0d]: got %0b want 1", i, out_valid);
      end
      n_cmp++;
      if ({n11_r, n11_i} !== {er, ei}) begin
        n_err++;
        $display("FAIL rot_n11[%0d]: got (%0d,%0d) want (%0d,%0d)", i, n11_r, n11_i, er, ei);
      end
      n_cmp++;
      if ({n00_r, n00_i, n01_r, n01_i, n10_r, n10_i} !== {pr, pi, pi, pr, pr, ~pi}) begin
        n_err++;
        $display("FAIL rot_pass[%0d]: got n00=(%0d,%0d) n01=(%0d,%0d) n10=(%0d,%0d) want n00=(%0d,%0d) n01=(%0d,%0d) n10=(%0d,%0d)",
                 i, n00_r, n00_i, n01_r, n01_i, n10_r, n10_i, pr, pi, pi, pr, pr, ~pi);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int tab [3][7] = '{'{4, -1, 0, 0, 0, -1, -1},
                       '{3, 127, 127, 12, -12, 0, 127},
                       '{3, -128, -128, -128, 127, 0, -128}};
    logic signed [7:0] er, ei;
    for (int i = 0; i < 3; i++) begin
      er = 8'(tab[i][5]);
      ei = 8'(tab[i][6]);
      drive_vec(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
      @(negedge clk);
      drive_idle();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL sat_valid[%0d]: got %0b want 1", i, out_valid);
      end
      n_cmp++;
      if ({n11_r, n11_i} !== {er, ei}) begin
        n_err++;
        $display("FAIL sat_n11[%0d]: got (%0d,%0d) want (%0d,%0d)", i, n11_r, n11_i, er, ei);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int c_tab [8] = '{16, -16, 0, 11, 15, 16, 16, 16};
    int s_tab [8] = '{0, 0, 16, 11, 6, 3, 2, 1};
    logic exp_v;
    logic signed [7:0] er, ei;
    for (int j = 0; j < 13; j++) begin
      exp_v = (j >= 4 && j < 12);
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_err++;
        $display("FAIL stream_valid[%0d]: got %0b want %0b", j, out_valid, exp_v);
      end
      if (j >= 4 && j < 12) begin
        er = 8'(c_tab[j-4]);
        ei = 8'(s_tab[j-4]);
        n_cmp++;
        if ({n11_r, n11_i} !== {er, ei}) begin
          n_err++;
          $display("FAIL stream_n11[k=%0d]: got (%0d,%0d) want (%0d,%0d)", j-4, n11_r, n11_i, er, ei);
        end
      end
      if (j < 8) drive_vec(j, 16, 0, j, -j);
      else drive_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_bubbles();
    logic exp_v;
    logic signed [7:0] er, ei;
    for (int j = 0; j < 9; j++) begin
      exp_v = (j == 4 || j == 6 || j == 7);
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_err++;
        $display("FAIL bubble_valid[%0d]: got %0b want %0b", j, out_valid, exp_v);
      end
      if (j >= 4) begin
        if (j <= 5)      begin er = 8'sd10; ei = -8'sd20; end
        else if (j == 6) begin er = -8'sd7; ei = -8'sd3;  end
        else             begin er = -8'sd4; ei = 8'sd8;   end
        n_cmp++;
        if ({n11_r, n11_i} !== {er, ei}) begin
          n_err++;
          $display("FAIL bubble_n11[%0d]: got (%0d,%0d) want (%0d,%0d)", j, n11_r, n11_i, er, ei);
        end
      end
      if (j == 5) begin
        n_cmp++;
        if ({n00_r, n00_i} !== {8'sd1, 8'sd2}) begin
          n_err++;
          $display("FAIL bubble_hold_n00: got (%0d,%0d) want (1,2)", n00_r, n00_i);
        end
      end
      if (j == 0)      drive_vec(0, 10, -20, 1, 2);
      else if (j == 2) drive_vec(1, 7, 3, 3, 4);
      else if (j == 3) drive_vec(2, 8, 4, 5, 6);
      else             drive_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    drive_vec(1, 16, 0, 9, 9);
    @(negedge clk);
    drive_vec(2, 16, 0, 9, 9);
    @(negedge clk);
    drive_vec(3, 16, 0, 9, 9);
    rst_s_n = 1'b0;
    @(negedge clk);
    rst_s_n = 1'b1;
    drive_idle();
    n_cmp++;
    if ({out_valid, n00_r, n00_i, n11_r, n11_i} !== 33'd0) begin
      n_err++;
      $display("FAIL midrst_cleared: got valid=%0b n11=(%0d,%0d) n00=(%0d,%0d) want all 0",
               out_valid, n11_r, n11_i, n00_r, n00_i);
    end
    for (int j = 3; j < 10; j++) begin
      if (j < 9) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_ghost_valid[%0d]: got %0b want 0", j, out_valid);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL midrst_new_valid: got %0b want 1", out_valid);
        end
        n_cmp++;
        if ({n11_r, n11_i, n00_r, n00_i} !== {8'sd11, 8'sd11, 8'sd5, -8'sd3}) begin
          n_err++;
          $display("FAIL midrst_new_data: got n11=(%0d,%0d) n00=(%0d,%0d) want n11=(11,11) n00=(5,-3)",
                   n11_r, n11_i, n00_r, n00_i);
        end
      end
      if (j == 5) drive_vec(3, 16, 0, 5, -3);
      else        drive_idle();
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_s_n = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_rotation();
    test_saturation();
    test_back_to_back();
    test_bubbles();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
